// File: rtl/ctrl_decode_pipe.sv
// Single-slot decode stage: decodes an RV32I control word plus effective address into
// a registered control bundle behind a valid/ready handshake, with optional IO wait-states.
module ctrl_decode_pipe #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   IO_BASE   = 32'hFFFFFC00,
  parameter logic [XLEN-1:0]   RAM_LIMIT = 32'h00010000,
  parameter int unsigned       IO_WAIT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            io_read,
  output logic            io_write,
  output logic            mem_or_io_to_reg,
  output logic            sftmd,
  output logic            jal,
  output logic            jalr,
  output logic [2:0]      br_type,
  output logic            illegal,
  output logic            addr_fault,
  output logic            busy
);

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FULL} state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       io_read;
    logic       io_write;
    logic       mem_or_io_to_reg;
    logic       sftmd;
    logic       jal;
    logic       jalr;
    logic [2:0] br_type;
    logic       illegal;
    logic       addr_fault;
  } ctrl_t;

  localparam logic [2:0] BR_NONE   = 3'b010;
  localparam logic [3:0] WAIT_INIT = 4'(IO_WAIT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR = 4'd3,
                         ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10, ALU_AUIPC = 4'd11;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      bundle_q, bundle_d;

  ctrl_t      dec;
  logic       dec_ill;
  logic       is_ls;
  logic       dec_io_wait;
  logic       accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       addr_is_io;
  logic       addr_is_ram;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};
  assign addr_is_io    = (addr >= IO_BASE);
  assign addr_is_ram   = (addr < RAM_LIMIT);

  always_comb begin
    dec         = '0;
    dec.br_type = BR_NONE;
    dec_ill     = 1'b0;
    is_ls       = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.alu_op = ALU_ADD;
          {7'h20, 3'b000}: dec.alu_op = ALU_SUB;
          {7'h00, 3'b001}: begin dec.alu_op = ALU_SLL; dec.sftmd = 1'b1; end
          {7'h00, 3'b010}: dec.alu_op = ALU_SLT;
          {7'h00, 3'b011}: dec.alu_op = ALU_SLTU;
          {7'h00, 3'b100}: dec.alu_op = ALU_XOR;
          {7'h00, 3'b101}: begin dec.alu_op = ALU_SRL; dec.sftmd = 1'b1; end
          {7'h20, 3'b101}: begin dec.alu_op = ALU_SRA; dec.sftmd = 1'b1; end
          {7'h00, 3'b110}: dec.alu_op = ALU_OR;
          {7'h00, 3'b111}: dec.alu_op = ALU_AND;
          default:         dec_ill = 1'b1;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec.sftmd  = 1'b1;
            dec_ill    = (funct7 != 7'h00);
          end
          default: begin
            dec.sftmd = 1'b1;
            if (funct7 == 7'h00)      dec.alu_op = ALU_SRL;
            else if (funct7 == 7'h20) dec.alu_op = ALU_SRA;
            else                      dec_ill = 1'b1;
          end
        endcase
      end
      OP_LOAD, OP_STORE: begin
        is_ls       = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_op  = ALU_ADD;
        if (opcode == OP_LOAD) begin
          dec.reg_write        = 1'b1;
          dec.mem_or_io_to_reg = 1'b1;
        end
        // IO decode takes priority so an overlapping RAM window can never shadow IO.
        if (addr_is_io) begin
          dec.io_read  = (opcode == OP_LOAD);
          dec.io_write = (opcode == OP_STORE);
        end else if (addr_is_ram) begin
          dec.mem_read  = (opcode == OP_LOAD);
          dec.mem_write = (opcode == OP_STORE);
        end else begin
          dec.addr_fault       = 1'b1;
          dec.reg_write        = 1'b0;
          dec.mem_or_io_to_reg = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_ill = 1'b1;
        else                                      dec.br_type = funct3;
      end
      OP_JAL: begin
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_AUIPC;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec         = '0;
      dec.br_type = BR_NONE;
      dec.illegal = 1'b1;
    end
  end

  assign dec_io_wait = is_ls && addr_is_io && (WAIT_INIT != 4'd0);

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_FULL);
  assign busy      = (state_q != ST_EMPTY);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!accept && out_ready) state_d = ST_EMPTY;
      end
      default: ;
    endcase
    // A new word can land from EMPTY or straight behind a consumed FULL slot.
    if (accept) begin
      bundle_d = dec;
      if (dec_io_wait) begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = ST_FULL;
        cnt_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_EMPTY;
      cnt_q            <= 4'd0;
      bundle_q         <= '0;
      bundle_q.br_type <= BR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
    end
  end

  assign alu_op           = bundle_q.alu_op;
  assign alu_src          = bundle_q.alu_src;
  assign reg_write        = bundle_q.reg_write;
  assign mem_read         = bundle_q.mem_read;
  assign mem_write        = bundle_q.mem_write;
  assign io_read          = bundle_q.io_read;
  assign io_write         = bundle_q.io_write;
  assign mem_or_io_to_reg = bundle_q.mem_or_io_to_reg;
  assign sftmd            = bundle_q.sftmd;
  assign jal              = bundle_q.jal;
  assign jalr             = bundle_q.jalr;
  assign br_type          = bundle_q.br_type;
  assign illegal          = bundle_q.illegal;
  assign addr_fault       = bundle_q.addr_fault;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: hand-computed decode bundles, IO wait-states,
// backpressure and asynchronous reset.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, io_read, io_write;
  logic        mem_or_io_to_reg, sftmd, jal, jalr;
  logic [2:0]  br_type;
  logic        illegal, addr_fault, busy;

  int checks   = 0;
  int failures = 0;

  ctrl_decode_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .io_read(io_read), .io_write(io_write),
    .mem_or_io_to_reg(mem_or_io_to_reg), .sftmd(sftmd),
    .jal(jal), .jalr(jalr), .br_type(br_type),
    .illegal(illegal), .addr_fault(addr_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observed bundle: {alu_op, 10 flags, br_type, illegal, addr_fault}
  logic [18:0] obs;
  assign obs = {alu_op, alu_src, reg_write, mem_read, mem_write, io_read, io_write,
                mem_or_io_to_reg, sftmd, jal, jalr, br_type, illegal, addr_fault};

  // flags order: alu_src reg_write mem_read mem_write io_read io_write m2r sftmd jal jalr
  function automatic logic [18:0] pk(input logic [3:0] op, input logic [9:0] fl,
                                     input logic [2:0] br, input logic ill, input logic flt);
    return {op, fl, br, ill, flt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one word from an empty stage with out_ready=1, check the bundle, then drain.
  task automatic single(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [18:0] exp);
    in_valid    = 1'b1;
    instruction = ins;
    addr        = a;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    $display("txn %s instr=%08h addr=%08h out_valid=%0b bundle=%05h", tag, ins, a, out_valid, obs);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_bundle"}, {13'd0, obs}, {13'd0, exp});
    step();
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  localparam logic [2:0] BN = 3'b010;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    instruction = 32'd0;
    addr        = 32'd0;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_bundle", {13'd0, obs}, {13'd0, pk(4'd0, 10'b0, BN, 1'b0, 1'b0)});
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add x3,x1,x2 : in_ready must remain 1 while FULL with out_ready=1
    in_valid = 1'b1; instruction = 32'h002081B3; addr = 32'd0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    $display("txn add instr=002081b3 out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_in_ready", {31'd0, in_ready}, 32'd1);
    check("add_bundle", {13'd0, obs}, {13'd0, pk(4'd0, 10'b0100000000, BN, 1'b0, 1'b0)});
    step();
    check("add_empty_busy", {31'd0, busy}, 32'd0);

    single("sub",    32'h40208133, 32'd0, pk(4'd1,  10'b0100000000, BN, 1'b0, 1'b0));
    single("sra",    32'h4020D1B3, 32'd0, pk(4'd7,  10'b0100000100, BN, 1'b0, 1'b0));
    single("xori",   32'h0050C193, 32'd0, pk(4'd2,  10'b1100000000, BN, 1'b0, 1'b0));
    single("srli_bad", 32'h0220D193, 32'd0, pk(4'd0, 10'b0, BN, 1'b1, 1'b0));
    single("op7f",   32'h0000007F, 32'd0, pk(4'd0,  10'b0, BN, 1'b1, 1'b0));
    single("sw_ram", 32'h0020A023, 32'h0000FFFC, pk(4'd0, 10'b1001000000, BN, 1'b0, 1'b0));
    single("sw_flt", 32'h0020A023, 32'h00010000, pk(4'd0, 10'b1000000000, BN, 1'b0, 1'b1));
    single("lw_top", 32'h0000A183, 32'h0000FFFF, pk(4'd0, 10'b1110001000, BN, 1'b0, 1'b0));
    single("beq",    32'h00208063, 32'd0, pk(4'd0,  10'b0, 3'b000, 1'b0, 1'b0));
    single("bgeu",   32'h0020F063, 32'd0, pk(4'd0,  10'b0, 3'b111, 1'b0, 1'b0));
    single("br_bad", 32'h0020A063, 32'd0, pk(4'd0,  10'b0, BN, 1'b1, 1'b0));
    single("jal_io", 32'h008000EF, 32'hFFFFFFFF, pk(4'd0, 10'b0100000010, BN, 1'b0, 1'b0));
    single("jalr",   32'h000100E7, 32'd0, pk(4'd0,  10'b1100000001, BN, 1'b0, 1'b0));
    single("lui",    32'h123452B7, 32'd0, pk(4'd10, 10'b1100000000, BN, 1'b0, 1'b0));
    single("auipc",  32'h12345297, 32'd0, pk(4'd11, 10'b1100000000, BN, 1'b0, 1'b0));

    // lw from IO_BASE: two wait cycles, then presented on the third
    in_valid = 1'b1; instruction = 32'h0000A183; addr = 32'hFFFFFC00; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("io_w1_ready", {31'd0, in_ready}, 32'd0);
    check("io_w1_valid", {31'd0, out_valid}, 32'd0);
    check("io_w1_busy", {31'd0, busy}, 32'd1);
    step();
    check("io_w2_ready", {31'd0, in_ready}, 32'd0);
    check("io_w2_valid", {31'd0, out_valid}, 32'd0);
    step();
    $display("txn lw_io addr=fffffc00 out_valid=%0b bundle=%05h", out_valid, obs);
    check("io_valid", {31'd0, out_valid}, 32'd1);
    check("io_bundle", {13'd0, obs}, {13'd0, pk(4'd0, 10'b1100101000, BN, 1'b0, 1'b0)});
    step();
    check("io_drain", {31'd0, out_valid}, 32'd0);

    // Back-to-back add, sub, xori with two stalled cycles after the first
    in_valid = 1'b1; instruction = 32'h002081B3; out_ready = 1'b1; addr = 32'd0;
    step();
    instruction = 32'h40208133;
    out_ready   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      $display("txn stall%0d out_valid=%0b in_ready=%0b bundle=%05h", i, out_valid, in_ready, obs);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_bundle", {13'd0, obs}, {13'd0, pk(4'd0, 10'b0100000000, BN, 1'b0, 1'b0)});
    end
    out_ready = 1'b1;
    step();
    instruction = 32'h0050C193;
    $display("txn bp_second bundle=%05h", obs);
    check("bp_second", {13'd0, obs}, {13'd0, pk(4'd1, 10'b0100000000, BN, 1'b0, 1'b0)});
    step();
    in_valid = 1'b0;
    $display("txn bp_third bundle=%05h", obs);
    check("bp_third", {13'd0, obs}, {13'd0, pk(4'd2, 10'b1100000000, BN, 1'b0, 1'b0)});
    check("bp_third_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("bp_done", {31'd0, out_valid}, 32'd0);

    // Reset asserted between edges while waiting on an IO load
    in_valid = 1'b1; instruction = 32'h0000A183; addr = 32'hFFFFFC00; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("rw_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_valid", {31'd0, out_valid}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_in_ready", {31'd0, in_ready}, 32'd1);
    check("rw_bundle", {13'd0, obs}, {13'd0, pk(4'd0, 10'b0, BN, 1'b0, 1'b0)});
    #1;
    rst = 1'b0;
    single("lw_after_rst", 32'h0000A183, 32'h00000100, pk(4'd0, 10'b1110001000, BN, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
